// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: branch opcode, 2-bit predictor encodings
// and the B-type immediate decoder.
package fetch_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_cnt_e;

  // B-type offset: imm[12|10:5] in inst[31:25], imm[4:1|11] in inst[11:7], bit 0 is zero
  function automatic logic [31:0] b_imm(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_ctrl_bht.sv
// Bimodal branch history table: 2-bit saturating counters, asynchronous read,
// synchronous update. A same-cycle read of the entry being written sees the old value.
module bht
  import fetch_pkg::*;
#(
  parameter int          BHT_ENTRIES = 64,
  parameter logic [1:0]  BHT_INIT    = 2'b01,
  localparam int         IDX         = $clog2(BHT_ENTRIES)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [IDX-1:0] rd_idx,
  output logic [1:0]     rd_cnt,
  input  logic           wr_en,
  input  logic [IDX-1:0] wr_idx,
  input  logic           wr_taken
);

  logic [1:0] r_cnt [BHT_ENTRIES];

  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
    if (up)
      return (cnt == ST) ? ST : cnt + 2'd1;
    else
      return (cnt == SNT) ? SNT : cnt - 2'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) r_cnt[i] <= BHT_INIT;
    end else if (wr_en) begin
      r_cnt[wr_idx] <= sat_step(r_cnt[wr_idx], wr_taken);
    end
  end

  assign rd_cnt = r_cnt[rd_idx];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: PC register, next-PC selection, bimodal prediction carried
// alongside IF/ID and ID/EX, and resolved-branch / misprediction counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BHT_ENTRIES = 64,
  parameter logic [1:0]  BHT_INIT    = 2'b01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_inst,
  input  logic        id_branch,
  input  logic [31:0] id_target,
  input  logic        ex_stall,
  input  logic        ex_branch,
  input  logic        ex_zero,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  output logic [31:0] if_pc,
  output logic        if_take,
  output logic        mispredict,
  output logic [31:0] br_count,
  output logic [31:0] mp_count
);

  localparam int IDX = $clog2(BHT_ENTRIES);

  logic [31:0] r_pc_p0;
  logic        r_pred_p1;
  logic        r_pred_p2;
  logic [31:0] r_br_count;
  logic [31:0] r_mp_count;

  logic [1:0]  w_rd_cnt;
  logic        w_take;
  logic        w_mispredict;
  logic [31:0] w_next_pc;
  logic        w_pred_p1_nxt;
  logic        w_pred_p2_nxt;

  bht #(
    .BHT_ENTRIES (BHT_ENTRIES),
    .BHT_INIT    (BHT_INIT)
  ) u_bht (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (r_pc_p0[IDX+1:2]),
    .rd_cnt   (w_rd_cnt),
    .wr_en    (ex_branch),
    .wr_idx   (ex_pc[IDX+1:2]),
    .wr_taken (ex_zero)
  );

  assign w_take       = (if_inst[6:0] == OPC_BRANCH) && w_rd_cnt[1];
  assign w_mispredict = ex_branch && (ex_zero != r_pred_p2);

  // A misprediction overrides the stall: the wrong-path work must be discarded regardless
  always_comb begin
    w_next_pc = r_pc_p0 + 32'd4;
    if (w_mispredict)
      w_next_pc = ex_zero ? ex_target : ex_pc + 32'd4;
    else if (ex_stall)
      w_next_pc = r_pc_p0;
    else if (id_branch)
      w_next_pc = id_target;
    else if (w_take)
      w_next_pc = r_pc_p0 + b_imm(if_inst);
  end

  always_comb begin
    w_pred_p1_nxt = w_take;
    if (w_mispredict)   w_pred_p1_nxt = 1'b0;
    else if (ex_stall)  w_pred_p1_nxt = r_pred_p1;
    else if (id_branch) w_pred_p1_nxt = 1'b0;
    w_pred_p2_nxt = (w_mispredict || ex_stall) ? 1'b0 : r_pred_p1;
  end

  // p0: fetch address, p1: prediction in ID, p2: prediction in EX
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc_p0    <= RESET_PC;
      r_pred_p1  <= 1'b0;
      r_pred_p2  <= 1'b0;
      r_br_count <= 32'd0;
      r_mp_count <= 32'd0;
    end else begin
      r_pc_p0    <= w_next_pc;
      r_pred_p1  <= w_pred_p1_nxt;
      r_pred_p2  <= w_pred_p2_nxt;
      r_br_count <= r_br_count + {31'd0, ex_branch};
      r_mp_count <= r_mp_count + {31'd0, w_mispredict};
    end
  end

  assign if_pc      = r_pc_p0;
  assign if_take    = w_take;
  assign mispredict = w_mispredict;
  assign br_count   = r_br_count;
  assign mp_count   = r_mp_count;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed training/stall/jump/wrap sequences followed
// by random traffic, all checked against a behavioural model of the fetch rules.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0200;
  localparam int          NENT   = 64;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] if_inst = NOP;
  logic        id_branch = 1'b0;
  logic [31:0] id_target = 32'd0;
  logic        ex_stall = 1'b0;
  logic        ex_branch = 1'b0;
  logic        ex_zero = 1'b0;
  logic [31:0] ex_pc = 32'd0;
  logic [31:0] ex_target = 32'd0;
  logic [31:0] if_pc;
  logic        if_take;
  logic        mispredict;
  logic [31:0] br_count;
  logic [31:0] mp_count;

  fetch_ctrl #(
    .RESET_PC    (RST_PC),
    .BHT_ENTRIES (NENT),
    .BHT_INIT    (2'b01)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .if_inst    (if_inst),
    .id_branch  (id_branch),
    .id_target  (id_target),
    .ex_stall   (ex_stall),
    .ex_branch  (ex_branch),
    .ex_zero    (ex_zero),
    .ex_pc      (ex_pc),
    .ex_target  (ex_target),
    .if_pc      (if_pc),
    .if_take    (if_take),
    .mispredict (mispredict),
    .br_count   (br_count),
    .mp_count   (mp_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          step;
    logic        take;
    logic        mp;
    logic [31:0] pc;
    logic [31:0] br;
    logic [31:0] mpc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   nstep  = 0;
  bit   g_force_mp = 1'b0;

  // behavioural reference state
  logic [31:0] m_pc;
  int          m_bht [NENT];
  logic        m_idp, m_exp;
  logic [31:0] m_br, m_mp;

  function automatic void m_reset();
    m_pc = RST_PC; m_idp = 1'b0; m_exp = 1'b0; m_br = 32'd0; m_mp = 32'd0;
    for (int i = 0; i < NENT; i++) m_bht[i] = 1;
  endfunction

  function automatic int ix(input logic [31:0] pc);
    return int'((pc >> 2) % NENT);
  endfunction

  function automatic logic [31:0] boff(input logic [31:0] inst);
    logic [31:0] o;
    o = inst[11:8] * 2 + inst[30:25] * 32 + inst[7] * 2048 - inst[31] * 4096;
    return o;
  endfunction

  function automatic logic [31:0] mk_b(input int off);
    logic [12:0] o;
    o = off[12:0];
    return {o[12], o[10:5], 10'd0, 3'b000, o[4:1], o[11], 7'b1100011};
  endfunction

  task automatic chk(input string nm, input int st, input logic [31:0] act, input logic [31:0] exv);
    checks++;
    if (act !== exv) begin
      errors++;
      $display("FAIL %s step=%0d actual=%h required=%h", nm, st, act, exv);
    end
  endtask

  task automatic step(input logic [31:0] inst, input logic idb, input logic [31:0] idt,
                      input logic stl, input logic exb, input logic exz,
                      input logic [31:0] expc, input logic [31:0] ext, input logic rst);
    exp_t        e;
    logic        tk, mp, nidp, nexp;
    logic [31:0] np;
    @(negedge clk);
    if (g_force_mp) begin
      dut.r_mp_count = 32'hFFFF_FFFF;
      m_mp = 32'hFFFF_FFFF;
      g_force_mp = 1'b0;
    end
    reset = rst; if_inst = inst; id_branch = idb; id_target = idt; ex_stall = stl;
    ex_branch = exb; ex_zero = exz; ex_pc = expc; ex_target = ext;
    if (rst) m_reset();
    tk = (inst[6:0] == 7'b1100011) && (m_bht[ix(m_pc)] >= 2);
    mp = !rst && exb && (exz != m_exp);
    if (!rst) begin
      if (mp)       np = exz ? ext : expc + 32'd4;
      else if (stl) np = m_pc;
      else if (idb) np = idt;
      else if (tk)  np = m_pc + boff(inst);
      else          np = m_pc + 32'd4;
      nidp = mp ? 1'b0 : stl ? m_idp : idb ? 1'b0 : tk;
      nexp = (mp || stl) ? 1'b0 : m_idp;
      if (exb) begin
        if (exz) m_bht[ix(expc)] = (m_bht[ix(expc)] == 3) ? 3 : m_bht[ix(expc)] + 1;
        else     m_bht[ix(expc)] = (m_bht[ix(expc)] == 0) ? 0 : m_bht[ix(expc)] - 1;
        m_br = m_br + 32'd1;
      end
      if (mp) m_mp = m_mp + 32'd1;
      m_pc = np; m_idp = nidp; m_exp = nexp;
    end
    e.step = nstep; e.take = tk; e.mp = mp; e.pc = m_pc; e.br = m_br; e.mpc = m_mp;
    sbq.push_back(e);
    nstep++;
  endtask

  task automatic nop_step();
    step(NOP, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic jump(input logic [31:0] tgt);
    step(NOP, 1'b1, tgt, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic resolve(input logic taken, input logic stl);
    step(NOP, 1'b0, 32'd0, stl, 1'b1, taken, 32'h40, 32'h60, 1'b0);
  endtask

  // monitor: combinational outputs mid-cycle, registered state just after the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("if_take", e.step, {31'd0, if_take}, {31'd0, e.take});
        chk("mispredict", e.step, {31'd0, mispredict}, {31'd0, e.mp});
        @(posedge clk);
        #1;
        chk("if_pc", e.step, if_pc, e.pc);
        chk("br_count", e.step, br_count, e.br);
        chk("mp_count", e.step, mp_count, e.mpc);
      end
    end
  end

  initial begin
    logic [31:0] inst, idt, expc, ext;
    logic        idb, stl, exb, exz, rst;
    m_reset();
    // power-on reset
    step(NOP, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    step(NOP, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    // training: BEQ at 0x40, offset +0x20, always taken
    jump(32'h40);
    step(mk_b(32'h20), 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    nop_step();
    resolve(1'b1, 1'b0);
    jump(32'h40);
    step(mk_b(32'h20), 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    nop_step();
    resolve(1'b1, 1'b0);
    // saturation then one not-taken, still predicts taken
    for (int i = 0; i < 4; i++) resolve(1'b1, 1'b0);
    resolve(1'b0, 1'b0);
    jump(32'h40);
    step(mk_b(32'h20), 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    // stall together with a misprediction
    nop_step();
    resolve(1'b0, 1'b1);
    // stall alone holds PC and ID prediction
    jump(32'h40);
    step(mk_b(32'h20), 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step(NOP, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    step(NOP, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    nop_step();
    resolve(1'b0, 1'b0);
    // jump in ID beats a taken prediction in IF
    jump(32'h40);
    step(mk_b(32'h20), 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    nop_step();
    resolve(1'b1, 1'b0);
    // PC wrap and counter wrap
    jump(32'hFFFF_FFFC);
    nop_step();
    nop_step();
    g_force_mp = 1'b1;
    resolve(1'b1, 1'b0);
    nop_step();
    // reset mid-run with nonzero state
    step(mk_b(32'h20), 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    step(NOP, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    nop_step();
    // random traffic
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 1) == 1)
        inst = mk_b(($urandom_range(0, 63) - 32) * 4);
      else
        inst = {$urandom(), 7'b0010011} >> 0;
      if ($urandom_range(0, 1) == 0) inst[6:0] = 7'b0110011;
      idb  = ($urandom_range(0, 9) == 0);
      idt  = {$urandom_range(0, 255), 2'b00};
      stl  = ($urandom_range(0, 6) == 0);
      rst  = ($urandom_range(0, 199) == 0);
      exb  = !rst && ($urandom_range(0, 2) == 0);
      exz  = $urandom_range(0, 1);
      expc = {$urandom_range(0, 127), 2'b00} | (($urandom_range(0, 3) == 0) ? 32'hFFFF_FE00 : 32'd0);
      ext  = {$urandom_range(0, 255), 2'b00};
      step(inst, idb, idt, stl, exb, exz, expc, ext, rst);
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", -1, sbq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout step=%0d actual=running required=finished", nstep);
    $fatal(1, "timeout");
  end

endmodule
